// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encodings and
// the iteration-counter width helper.
package mul_seq_pkg;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] NEGA  = 3'd1;
   localparam logic [2:0] NEGB  = 3'd2;
   localparam logic [2:0] MUL   = 3'd3;
   localparam logic [2:0] NEGLO = 3'd4;
   localparam logic [2:0] NEGHI = 3'd5;

   // Counter must hold the value N itself, hence the extra bit.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/mul_seq_rc_adder.sv
// N-bit ripple-carry adder; the single arithmetic resource of mul_seq.
module rc_adder #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s,
   output logic         c
);

   logic [N:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign s[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign c = carry[N];

endmodule

// File: rtl/mul_seq.sv
// Sequential NxN->2N signed/unsigned multiplier producing HI/LO. Operands are
// made non-negative, multiplied by shift-add, and the product negated if needed.
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         is_signed,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]  ONE     = {{(N-1){1'b0}}, 1'b1};

   logic [2:0]    state;
   logic [N-1:0]  mcand;
   logic [CW-1:0] cnt;
   logic          neg;
   logic          sgn;
   logic          cy;

   logic [N-1:0]  add_x;
   logic [N-1:0]  add_y;
   logic [N-1:0]  sum;
   logic          c;

   // Operand mux for the shared adder, selected by the current state.
   always_comb begin
      add_x = '0;
      add_y = '0;
      case (state)
         NEGA: begin
            add_x = ~mcand;
            add_y = ONE;
         end
         NEGB: begin
            add_x = ~lo;
            add_y = ONE;
         end
         MUL: begin
            add_x = hi;
            if (lo[0]) begin
               add_y = mcand;
            end else begin
               add_y = '0;
            end
         end
         NEGLO: begin
            add_x = ~lo;
            add_y = ONE;
         end
         NEGHI: begin
            add_x = ~hi;
            add_y = {{(N-1){1'b0}}, cy};
         end
         default: begin
            add_x = '0;
            add_y = '0;
         end
      endcase
   end

   rc_adder #(.N(N)) u_add (
      .a (add_x),
      .b (add_y),
      .s (sum),
      .c (c)
   );

   // FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
         cnt   <= '0;
         neg   <= 1'b0;
         sgn   <= 1'b0;
         cy    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= a;
                  lo    <= b;
                  hi    <= '0;
                  sgn   <= is_signed;
                  neg   <= is_signed & (a[N-1] ^ b[N-1]);
                  cnt   <= CW'(N);
                  state <= NEGA;
                  busy  <= 1'b1;
               end
            end
            NEGA: begin
               if (sgn & mcand[N-1]) mcand <= sum;
               state <= NEGB;
            end
            NEGB: begin
               if (sgn & lo[N-1]) lo <= sum;
               state <= MUL;
            end
            MUL: begin
               hi  <= {c, sum[N-1:1]};
               lo  <= {sum[0], lo[N-1:1]};
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) state <= NEGLO;
            end
            NEGLO: begin
               // cy carries the +1 into HI when LO negates to zero.
               if (neg) begin
                  lo <= sum;
                  cy <= c;
               end
               state <= NEGHI;
            end
            NEGHI: begin
               if (neg) hi <= sum;
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq (N=32): latency, signed/unsigned
// products, ignored starts, back-to-back issue and mid-operation reset.
module tb_mul_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors = 0;
   int errors  = 0;

   mul_seq #(.N(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request; returns #1 after the sampling edge E0.
   task automatic launch(input logic sg, input logic [31:0] av, input logic [31:0] bv);
      start     = 1'b1;
      is_signed = sg;
      a         = av;
      b         = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait for done (bounded), check latency, busy profile and the product.
   task automatic finish_op(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                            input logic disturb);
      int k;
      logic busy_ok;
      busy_ok = busy;
      k = 0;
      for (int i = 1; i <= 45; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            k = i;
            break;
         end
         busy_ok = busy_ok & busy;
         if (disturb) begin
            start = (i == 5 || i == 20);
            is_signed = ~is_signed;
            a = ~a ^ 32'h1234_5678;
            b = b + 32'd3;
         end
      end
      start = 1'b0;
      check({tag, "_latency"}, 64'(k), 64'd36);
      check({tag, "_busy_during"}, {63'd0, busy_ok}, 64'd1);
      check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      check({tag, "_product"}, {hi, lo}, {ehi, elo});
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);

      launch(1'b0, 32'd7, 32'd6);
      finish_op("u7x6", 32'h0000_0000, 32'h0000_002A, 1'b0);
      @(posedge clk);
      #1;
      check("done_one_cycle", {63'd0, done}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_in_idle", {hi, lo}, 64'h0000_0000_0000_002A);

      launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish_op("u_ffxff", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish_op("s_m1xm1", 32'h0000_0000, 32'h0000_0001, 1'b0);
      launch(1'b1, 32'hFFFF_FFFD, 32'd5);
      finish_op("s_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      launch(1'b1, 32'd0, 32'hFFFF_FFFB);
      finish_op("s_0xm5", 32'h0000_0000, 32'h0000_0000, 1'b0);
      launch(1'b1, 32'h8000_0000, 32'h8000_0000);
      finish_op("s_minxmin", 32'h4000_0000, 32'h0000_0000, 1'b0);
      launch(1'b1, 32'h8000_0000, 32'd1);
      finish_op("s_minx1", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

      // Starts at cycles 5 and 20 plus toggling operands must be ignored.
      launch(1'b0, 32'd1000, 32'd1000);
      finish_op("ignore_start", 32'h0000_0000, 32'h000F_4240, 1'b1);
      // Back-to-back issue in the done cycle.
      launch(1'b1, 32'd100, 32'hFFFF_FFF9);
      finish_op("back2back", 32'hFFFF_FFFF, 32'hFFFF_FD44, 1'b0);

      // Reset in cycle 15 of an operation.
      launch(1'b1, 32'h1234_5678, 32'h8765_4321);
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_done", {63'd0, done}, 64'd0);
      check("midrst_hilo", {hi, lo}, 64'd0);
      launch(1'b0, 32'd2, 32'd3);
      finish_op("after_rst", 32'h0000_0000, 32'h0000_0006, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential N×N→2N multiplier for the MIPS `mult`/`multu` path, producing the HI/LO register pair. It time-shares a single `rc_adder` instance across three jobs: operand negation, shift-add accumulation and result negation. The execute stage issues a one-cycle `start`, sees `busy` while the block works, and receives a one-cycle `done` pulse with HI/LO valid. Latency is fixed at N+4 cycles, independent of operand values and signedness.

## Interface
- `N`, default 32: operand width in bits, ≥ 2.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `is_signed` in 1: 1 = `mult` (two's complement), 0 = `multu`; sampled with `start`.
- `a` in N: multiplicand; sampled with `start`.
- `b` in N: multiplier; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: registered one-cycle pulse; HI/LO are valid in that cycle.
- `hi` out N: upper product word.
- `lo` out N: lower product word.

## Operation
- States: IDLE → NEGA → NEGB → MUL (N cycles) → NEGLO → NEGHI → IDLE.
- IDLE, `start`=1: latch `a`→`mcand`, `b`→`lo`, clear `hi` to 0, latch `is_signed`.
  - Set `neg` = `is_signed` & (a[N-1] ^ b[N-1]).
  - Load `cnt` with N.
- NEGA: adder gets `~mcand` and 1. Write the sum to `mcand` only if `is_signed` & `mcand[N-1]`.
- NEGB: adder gets `~lo` and 1. Write the sum to `lo` only if `is_signed` & `lo[N-1]`.
- MUL, each cycle: adder gets `hi` and (`lo[0]` ? `mcand` : 0), giving sum `s` and carry `c`.
  - {hi, lo} ← {c, s, lo[N-1:1]}.
  - `cnt` decrements by 1; exit to NEGLO when `cnt` reaches 1 at the edge, which gives exactly N iterations.
- NEGLO: adder gets `~lo` and 1.
  - If `neg`: `lo` ← sum and `cy` ← carry.
  - Otherwise `lo` is unchanged and `cy` is don't-care.
- NEGHI: adder gets `~hi` and {0…0, `cy`}. If `neg`, `hi` ← sum. Next state is IDLE, and `done` ← 1 at this edge.
- Arithmetic rules:
  - All adds are modulo 2^N.
  - The magnitude of −2^(N-1) is 2^(N-1), which is correct as unsigned.
  - Negating a zero product yields zero: the carry propagates to `hi`.
- `hi`/`lo` hold their last result in IDLE until the next accepted `start`. Intermediate values are visible while `busy`=1 and are not valid then.
- `start` while `busy`=1 is ignored; no queuing.
- Input changes after the sampling edge have no effect.
- `rst` at any time, including mid-operation:
  - State goes to IDLE.
  - `busy`, `done`, `hi`, `lo`, `mcand`, `cnt`, `neg` and `cy` all go to 0.
  - The operation is abandoned.

## Timing
- Edge E0 samples `start`=1 in IDLE. `busy`=1 from the cycle after E0.
- E1 = NEGA, E2 = NEGB, E3…E(N+2) = MUL, E(N+3) = NEGLO, E(N+4) = NEGHI.
- `done`=1 and `busy`=0 in the cycle after E(N+4): N+4 cycles after E0, 36 for N=32.
- A new `start` is accepted in the same cycle `done` is high (back-to-back). The next result appears N+4 cycles later.
- The path from the adder to the registers is a single-cycle ripple: the full N-bit carry chain must close within one clock.

## Structure
- Shared header/package `mul_seq_pkg`:
  - State encoding constants: IDLE, NEGA, NEGB, MUL, NEGLO, NEGHI.
  - `cnt` width = clog2(N)+1.
- Exactly one sub-module: a single `rc_adder #(.N(N))` instance.
  - Its operands are driven by a state-selected mux.
  - Its carry output `c` is consumed in MUL and NEGLO.
- No other adders or subtractors are inferred; negation always goes through the shared adder.

## Test plan
- Unsigned 7×6, `start` at E0 → `done` exactly at cycle 36, `hi`=0x00000000, `lo`=0x0000002A; `busy` high for cycles 1–35.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. The same operands signed → `hi`=0x00000000, `lo`=0x00000001.
- Signed −3×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Signed 0×−5 → `hi`=0, `lo`=0.
- Signed 0x80000000×0x80000000 → `hi`=0x40000000, `lo`=0x00000000. Signed 0x80000000×1 → `hi`=0xFFFFFFFF, `lo`=0x80000000.
- `start` pulsed at cycles 5 and 20 with different operands during an operation, plus operand inputs toggled mid-op → only the first result is produced, still at cycle 36. A second `start` in the `done` cycle → the next result arrives 36 cycles later.
- `rst` at cycle 15 of an operation → the following cycle has `busy`=0, `done`=0, `hi`=`lo`=0. A fresh 2×3 issued afterwards → `lo`=6, `hi`=0, 36 cycles after its `start`.
